collision_pair_scheduler: RTL and testbench

Sweeps every unordered pair of bodies held in the body RAM and presents each pair to the combinational `collision_detector`. It samples `is_collision` and streams colliding index pairs downstream over a valid/ready handshake. It sits upstream of the detector, reading the body RAM, and issues one full pair sweep per `start` pulse, typically once per physics frame.

---
 rtl/collision_pair_scheduler.sv | 160 ++++++++++++++++
 tb/tb_collision_pair_scheduler.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/collision_pair_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | collision_pair_scheduler                                                 |
// | Sweeps all unordered body pairs and streams the colliding (i,j) pairs.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module collision_pair_scheduler #(
   parameter int N_BODIES = 8,
   parameter int IDX_W    = 3,
   parameter int COUNT_W  = 8
) (
   input  logic                Clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic [N_BODIES-1:0] active_mask,
   output logic                busy,
   output logic                done,
   output logic [IDX_W-1:0]    body_rd_addr,
   input  logic [191:0]        body_rd_data,
   output logic [191:0]        bodyA,
   output logic [191:0]        bodyB,
   input  logic                is_collision,
   output logic                pair_valid,
   input  logic                pair_ready,
   output logic [IDX_W-1:0]    pair_i,
   output logic [IDX_W-1:0]    pair_j,
   output logic [COUNT_W-1:0]  pair_count
);

   localparam logic [3:0] c_S_IDLE  = 4'd0;
   localparam logic [3:0] c_S_RD_A  = 4'd1;
   localparam logic [3:0] c_S_CAP_A = 4'd2;
   localparam logic [3:0] c_S_RD_B  = 4'd3;
   localparam logic [3:0] c_S_CAP_B = 4'd4;
   localparam logic [3:0] c_S_EVAL  = 4'd5;
   localparam logic [3:0] c_S_EMIT  = 4'd6;
   localparam logic [3:0] c_S_NEXT  = 4'd7;
   localparam logic [3:0] c_S_DONE  = 4'd8;

   localparam logic [IDX_W-1:0] c_LAST_I = IDX_W'(N_BODIES - 2);
   localparam logic [IDX_W-1:0] c_LAST_J = IDX_W'(N_BODIES - 1);

   logic [3:0]          r_state;
   logic [IDX_W-1:0]    r_i;
   logic [IDX_W-1:0]    r_j;
   logic [N_BODIES-1:0] r_mask;
   logic [191:0]        r_body_a;
   logic [191:0]        r_body_b;
   logic [IDX_W-1:0]    r_pair_i;
   logic [IDX_W-1:0]    r_pair_j;
   logic [COUNT_W-1:0]  r_count;
   logic [IDX_W-1:0]    w_rd_addr;

   // Address is only driven for bodies that will actually be read.
   always_comb begin
      w_rd_addr = '0;
      if (r_state == c_S_RD_A && r_mask[r_i]) begin
         w_rd_addr = r_i;
      end else if (r_state == c_S_RD_B && r_mask[r_j]) begin
         w_rd_addr = r_j;
      end
   end

   always_ff @(posedge Clk) begin
      if (!reset_n) begin
         r_state  <= c_S_IDLE;
         r_i      <= '0;
         r_j      <= '0;
         r_mask   <= '0;
         r_body_a <= '0;
         r_body_b <= '0;
         r_pair_i <= '0;
         r_pair_j <= '0;
         r_count  <= '0;
      end else begin
         case (r_state)
            c_S_IDLE: begin
               if (start) begin
                  r_i     <= '0;
                  r_j     <= IDX_W'(1);
                  r_mask  <= active_mask;
                  r_count <= '0;
                  r_state <= c_S_RD_A;
               end
            end
            c_S_RD_A: begin
               if (!r_mask[r_i]) begin
                  if (r_i == c_LAST_I) begin
                     r_state <= c_S_DONE;
                  end else begin
                     r_i <= r_i + IDX_W'(1);
                     r_j <= r_i + IDX_W'(2);
                  end
               end else begin
                  r_state <= c_S_CAP_A;
               end
            end
            c_S_CAP_A: begin
               r_body_a <= body_rd_data;
               r_state  <= c_S_RD_B;
            end
            c_S_RD_B: begin
               r_state <= r_mask[r_j] ? c_S_CAP_B : c_S_NEXT;
            end
            c_S_CAP_B: begin
               r_body_b <= body_rd_data;
               r_state  <= c_S_EVAL;
            end
            c_S_EVAL: begin
               // Both records have been stable a full cycle, so the detector has settled.
               if (is_collision) begin
                  if (r_count != '1) begin
                     r_count <= r_count + COUNT_W'(1);
                  end
                  r_pair_i <= r_i;
                  r_pair_j <= r_j;
                  r_state  <= c_S_EMIT;
               end else begin
                  r_state <= c_S_NEXT;
               end
            end
            c_S_EMIT: begin
               if (pair_ready) begin
                  r_state <= c_S_NEXT;
               end
            end
            c_S_NEXT: begin
               if (r_j < c_LAST_J) begin
                  r_j     <= r_j + IDX_W'(1);
                  r_state <= c_S_RD_B;
               end else if (r_i < c_LAST_I) begin
                  r_i     <= r_i + IDX_W'(1);
                  r_j     <= r_i + IDX_W'(2);
                  r_state <= c_S_RD_A;
               end else begin
                  r_state <= c_S_DONE;
               end
            end
            c_S_DONE: begin
               r_state <= c_S_IDLE;
            end
            default: begin
               r_state <= c_S_IDLE;
            end
         endcase
      end
   end

   assign busy         = (r_state != c_S_IDLE);
   assign done         = (r_state == c_S_DONE);
   assign pair_valid   = (r_state == c_S_EMIT);
   assign body_rd_addr = w_rd_addr;
   assign bodyA        = r_body_a;
   assign bodyB        = r_body_b;
   assign pair_i       = r_pair_i;
   assign pair_j       = r_pair_j;
   assign pair_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_collision_pair_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_collision_pair_scheduler                                              |
// | Scoreboard bench with behavioural RAM, detector and sweep model.         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_collision_pair_scheduler;

   localparam int N = 8;

   typedef struct packed {
      logic [2:0] i;
      logic [2:0] j;
   } pair_t;

   logic         Clk = 1'b0;
   logic         reset_n;
   logic         start;
   logic [N-1:0] active_mask;
   logic         busy;
   logic         done;
   logic [2:0]   body_rd_addr;
   logic [191:0] body_rd_data;
   logic [191:0] bodyA;
   logic [191:0] bodyB;
   logic         is_collision;
   logic         pair_valid;
   logic         pair_ready;
   logic [2:0]   pair_i;
   logic [2:0]   pair_j;
   logic [7:0]   pair_count;

   logic [191:0] ram [N];
   pair_t        exp_q [$];
   int           checks;
   int           errors;
   int           ready_mode;
   int           bp_cnt;
   logic         addr_watch;
   logic [2:0]   forbid_addr;

   always #5 Clk = ~Clk;

   // Axis-aligned overlap on box centres: |d| < (size_a + size_b) / 2 in Q8.24.
   function automatic logic collide(input logic [191:0] a, input logic [191:0] b);
      longint dx, dy, hw, hh;
      dx = longint'($signed(a[175:144])) - longint'($signed(b[175:144]));
      dy = longint'($signed(a[143:112])) - longint'($signed(b[143:112]));
      if (dx < 0) dx = -dx;
      if (dy < 0) dy = -dy;
      hw = (longint'($signed(a[191:184])) + longint'($signed(b[191:184]))) <<< 23;
      hh = (longint'($signed(a[183:176])) + longint'($signed(b[183:176]))) <<< 23;
      return (dx < hw) && (dy < hh);
   endfunction

   function automatic logic [191:0] mk(input logic [7:0] w, input logic [7:0] h,
                                       input logic [31:0] px, input logic [31:0] py);
      return {w, h, px, py, 24'd0, 24'd0, 16'h4000, 16'h0000, 16'h0000, 16'h4000};
   endfunction

   assign is_collision = collide(bodyA, bodyB);

   always @(posedge Clk) body_rd_data <= ram[body_rd_addr];

   collision_pair_scheduler #(.N_BODIES(N), .IDX_W(3), .COUNT_W(8)) dut (
      .Clk          (Clk),
      .reset_n      (reset_n),
      .start        (start),
      .active_mask  (active_mask),
      .busy         (busy),
      .done         (done),
      .body_rd_addr (body_rd_addr),
      .body_rd_data (body_rd_data),
      .bodyA        (bodyA),
      .bodyB        (bodyB),
      .is_collision (is_collision),
      .pair_valid   (pair_valid),
      .pair_ready   (pair_ready),
      .pair_i       (pair_i),
      .pair_j       (pair_j),
      .pair_count   (pair_count)
   );

   task automatic chk(input string name, input logic [191:0] act, input logic [191:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference sweep: pairs in (i,j) order plus the cycle cost of the pass.
   task automatic model(input logic [N-1:0] mask, output int base, output int hits);
      pair_t p;
      base = 0;
      hits = 0;
      for (int i = 0; i < N - 1; i++) begin
         if (!mask[i]) begin
            base += 1;
         end else begin
            base += 2;
            for (int j = i + 1; j < N; j++) begin
               if (!mask[j]) begin
                  base += 2;
               end else begin
                  base += 4;
                  if (collide(ram[i], ram[j])) begin
                     hits++;
                     p.i = 3'(i);
                     p.j = 3'(j);
                     exp_q.push_back(p);
                  end
               end
            end
         end
      end
   endtask

   task automatic pulse_start(input logic [N-1:0] mask);
      @(posedge Clk);
      #1;
      active_mask = mask;
      start       = 1'b1;
      @(posedge Clk);
      #1;
      start = 1'b0;
   endtask

   task automatic run_sweep(input logic [N-1:0] mask, input int mode, input string tag,
                            input int fixed_done, input int fixed_hits);
      int   base, hits, cyc, vcyc, exp_done, exp_cnt;
      logic found;
      model(mask, base, hits);
      ready_mode = mode;
      pulse_start(mask);
      found = 1'b0;
      cyc   = 0;
      vcyc  = 0;
      while (!found && cyc < 3000) begin
         @(negedge Clk);
         cyc++;
         if (pair_valid) vcyc++;
         if (done) found = 1'b1;
      end
      if (!found) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout no done within %0d cycles", tag, cyc);
      end
      exp_done = base + 1 + ((mode == 0) ? hits : (mode == 2) ? hits * 6 : vcyc);
      exp_cnt  = (hits > 255) ? 255 : hits;
      chk({tag, "_done_cycle"}, 192'(cyc), 192'(exp_done));
      if (fixed_done >= 0) chk({tag, "_done_cycle_abs"}, 192'(cyc), 192'(fixed_done));
      chk({tag, "_pair_count"}, 192'(pair_count), 192'(exp_cnt));
      if (fixed_hits >= 0) chk({tag, "_pair_count_abs"}, 192'(pair_count), 192'(fixed_hits));
      @(negedge Clk);
      chk({tag, "_busy_after_done"}, 192'(busy), 192'(0));
      chk({tag, "_done_one_cycle"}, 192'(done), 192'(0));
      chk({tag, "_pairs_left"}, 192'(exp_q.size()), 192'(0));
      exp_q.delete();
   endtask

   // Downstream ready generator.
   initial begin
      pair_ready = 1'b0;
      bp_cnt     = 0;
      forever begin
         @(posedge Clk);
         #1;
         case (ready_mode)
            0: pair_ready = 1'b1;
            1: pair_ready = 1'($urandom_range(0, 1));
            default: begin
               if (pair_valid) bp_cnt++;
               else bp_cnt = 0;
               pair_ready = (bp_cnt >= 6);
            end
         endcase
      end
   end

   // Monitor: every presented pair must match the head of the expected queue.
   initial begin
      forever begin
         @(negedge Clk);
         if (reset_n === 1'b1 && pair_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pair actual=(%0d,%0d) required=none", pair_i, pair_j);
            end else begin
               chk("pair_i", 192'(pair_i), 192'(exp_q[0].i));
               chk("pair_j", 192'(pair_j), 192'(exp_q[0].j));
               chk("bodyA", bodyA, ram[exp_q[0].i]);
               chk("bodyB", bodyB, ram[exp_q[0].j]);
               if (pair_ready) void'(exp_q.pop_front());
            end
         end
         if (addr_watch && busy) chk("rd_addr_masked_body", 192'(body_rd_addr != forbid_addr), 192'(1));
      end
   end

   initial begin
      int lo, hi, cyc;
      logic saw_done;
      checks      = 0;
      errors      = 0;
      reset_n     = 1'b0;
      start       = 1'b0;
      active_mask = '0;
      ready_mode  = 0;
      addr_watch  = 1'b0;
      forbid_addr = 3'd1;
      for (int k = 0; k < N; k++) ram[k] = '0;

      // Reset, with a start pulse that must be ignored.
      repeat (2) @(posedge Clk);
      pulse_start(8'hFF);
      @(negedge Clk);
      chk("rst_busy", 192'(busy), 192'(0));
      chk("rst_done", 192'(done), 192'(0));
      chk("rst_addr", 192'(body_rd_addr), 192'(0));
      chk("rst_bodyA", bodyA, 192'(0));
      chk("rst_bodyB", bodyB, 192'(0));
      chk("rst_valid", 192'(pair_valid), 192'(0));
      chk("rst_pair_ij", 192'({pair_i, pair_j}), 192'(0));
      chk("rst_count", 192'(pair_count), 192'(0));
      reset_n = 1'b1;
      repeat (2) @(negedge Clk);
      chk("start_in_reset_ignored", 192'(busy), 192'(0));

      // No overlap.
      for (int k = 0; k < N; k++) ram[k] = mk(8'd10, 8'd10, 32'h0E00_0000 + 32'(k) * 32'h1400_0000, 32'h0E00_0000);
      run_sweep(8'hFF, 0, "no_overlap", 127, 0);

      // Single hit, then under backpressure, then with body 1 masked.
      ram[1] = mk(8'd10, 8'd10, 32'h1400_0000, 32'h0E00_0000);
      run_sweep(8'hFF, 0, "single_hit", 128, 1);
      run_sweep(8'hFF, 2, "backpressure", 133, 1);
      addr_watch = 1'b1;
      run_sweep(8'hFD, 0, "mask", -1, 0);
      addr_watch = 1'b0;

      // Mid-sweep reset: no done may appear, controller must be idle next cycle.
      model(8'hFF, lo, hi);
      ready_mode = 0;
      pulse_start(8'hFF);
      saw_done = 1'b0;
      for (cyc = 1; cyc <= 40; cyc++) begin
         @(negedge Clk);
         if (done) saw_done = 1'b1;
      end
      reset_n = 1'b0;
      @(negedge Clk);
      chk("midrst_busy", 192'(busy), 192'(0));
      chk("midrst_valid", 192'(pair_valid), 192'(0));
      exp_q.delete();
      reset_n = 1'b1;
      repeat (3) begin
         @(negedge Clk);
         if (done) saw_done = 1'b1;
      end
      chk("midrst_no_done", 192'(saw_done), 192'(0));

      // Restart with all bodies stacked: every pair collides.
      for (int k = 0; k < N; k++) ram[k] = mk(8'd10, 8'd10, 32'h2000_0000, 32'h2000_0000);
      run_sweep(8'hFF, 1, "stacked", -1, 28);

      // Randomized scenes.
      for (int it = 0; it < 10; it++) begin
         for (int k = 0; k < N; k++)
            ram[k] = mk(8'($urandom_range(1, 20)), 8'($urandom_range(1, 20)),
                        32'($urandom_range(0, 40)) << 24, 32'($urandom_range(0, 40)) << 24);
         run_sweep(8'($urandom_range(0, 255)), it % 2, "random", -1, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
